atm_account_server: RTL and testbench

Bank-side responder for the ATM controller: accepts one transaction request at a time over a valid/ready handshake and executes it against an on-chip account table. Supported operations are PIN verify, balance query, withdraw, deposit, transfer and PIN change. It enforces PIN-attempt lockout, balance sufficiency and overflow rules, then returns a status code and the resulting balance over a second valid/ready handshake. It sits between the ATM front-end FSM and the (future) host link.

---
 rtl/atm_account_server.sv | 201 ++++++++++++++++++++
 tb/tb_atm_account_server.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_server.sv
// Bank-side account server: takes one request at a time, scans the account table,
// applies PIN/lockout/balance rules and returns status plus resulting balance.
module atm_account_server #(
  parameter int          NUM_ACCTS = 4,
  parameter int          MAX_TRIES = 3,
  parameter logic [16:0] ACCT_BASE = 17'h04D2,
  parameter logic [16:0] PIN_BASE  = 17'h1F5E,
  parameter logic [18:0] INIT_BAL  = 19'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [16:0] req_acct,
  input  logic [16:0] req_pin,
  input  logic [16:0] req_dst_acct,
  input  logic [18:0] req_amount,
  input  logic [16:0] req_new_pin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_status,
  output logic [18:0] rsp_balance,
  output logic [1:0]  rsp_tries_left
);

  localparam int             IDX_W      = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCTS - 1);
  localparam logic [1:0]     TRIES_INIT = 2'(MAX_TRIES);

  localparam logic [2:0] OP_VERIFY = 3'd0, OP_BAL = 3'd1, OP_WD = 3'd2,
                         OP_DEP = 3'd3, OP_XFER = 3'd4, OP_CPIN = 3'd5;
  localparam logic [2:0] ST_OK = 3'd0, ST_BAD_ACCT = 3'd1, ST_BAD_PIN = 3'd2,
                         ST_LOCKED = 3'd3, ST_INSUF = 3'd4, ST_OVF = 3'd5,
                         ST_BAD_OP = 3'd6, ST_BAD_DST = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_DST_LOOKUP, S_EXEC, S_RESP} state_t;
  state_t state;

  logic [16:0] acct_tab  [NUM_ACCTS];
  logic [16:0] pin_tab   [NUM_ACCTS];
  logic [18:0] bal_tab   [NUM_ACCTS];
  logic [1:0]  tries_tab [NUM_ACCTS];

  logic [2:0]  op_q;
  logic [16:0] acct_q, pin_q, dst_q, new_pin_q;
  logic [18:0] amount_q;

  logic [IDX_W-1:0] scan_idx, src_idx, dst_idx;
  logic             src_found, dst_found;

  logic        scan_hit;
  logic [18:0] src_bal, dst_bal;
  logic [1:0]  src_tries;
  logic [19:0] dep_sum, dst_sum;

  assign scan_hit  = acct_tab[scan_idx] == ((state == S_DST_LOOKUP) ? dst_q : acct_q);
  assign src_bal   = bal_tab[src_idx];
  assign src_tries = tries_tab[src_idx];
  assign dst_bal   = bal_tab[dst_idx];
  assign dep_sum   = {1'b0, src_bal} + {1'b0, amount_q};
  assign dst_sum   = {1'b0, dst_bal} + {1'b0, amount_q};

  // Request fields are plain data: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      op_q      <= req_op;
      acct_q    <= req_acct;
      pin_q     <= req_pin;
      dst_q     <= req_dst_acct;
      amount_q  <= req_amount;
      new_pin_q <= req_new_pin;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_status     <= 3'd0;
      rsp_balance    <= 19'd0;
      rsp_tries_left <= 2'd0;
      scan_idx       <= '0;
      src_idx        <= '0;
      dst_idx        <= '0;
      src_found      <= 1'b0;
      dst_found      <= 1'b0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        acct_tab[i]  <= ACCT_BASE + 17'(i);
        pin_tab[i]   <= PIN_BASE + 17'(i);
        bal_tab[i]   <= INIT_BAL;
        tries_tab[i] <= TRIES_INIT;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            scan_idx  <= '0;
            src_found <= 1'b0;
            dst_found <= 1'b0;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (op_q[2:1] == 2'b11) begin
            rsp_status     <= ST_BAD_OP;
            rsp_balance    <= 19'd0;
            rsp_tries_left <= 2'd0;
            rsp_valid      <= 1'b1;
            state          <= S_RESP;
          end else begin
            if (scan_hit) begin
              src_found <= 1'b1;
              src_idx   <= scan_idx;
            end
            if (scan_idx == LAST_IDX) begin
              scan_idx <= '0;
              state    <= (op_q == OP_XFER && (scan_hit || src_found)) ? S_DST_LOOKUP : S_EXEC;
            end else begin
              scan_idx <= scan_idx + IDX_W'(1);
            end
          end
        end
        S_DST_LOOKUP: begin
          if (scan_hit) begin
            dst_found <= 1'b1;
            dst_idx   <= scan_idx;
          end
          if (scan_idx == LAST_IDX) begin
            scan_idx <= '0;
            state    <= S_EXEC;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        S_EXEC: begin
          rsp_valid <= 1'b1;
          state     <= S_RESP;
          if (!src_found) begin
            rsp_status     <= ST_BAD_ACCT;
            rsp_balance    <= 19'd0;
            rsp_tries_left <= 2'd0;
          end else if (src_tries == 2'd0) begin
            rsp_status     <= ST_LOCKED;
            rsp_balance    <= src_bal;
            rsp_tries_left <= 2'd0;
          end else if (pin_tab[src_idx] != pin_q) begin
            tries_tab[src_idx] <= src_tries - 2'd1;
            rsp_status         <= ST_BAD_PIN;
            rsp_balance        <= src_bal;
            rsp_tries_left     <= src_tries - 2'd1;
          end else begin
            tries_tab[src_idx] <= TRIES_INIT;
            rsp_tries_left     <= TRIES_INIT;
            rsp_status         <= ST_OK;
            rsp_balance        <= src_bal;
            case (op_q)
              OP_WD: begin
                if (amount_q > src_bal) rsp_status <= ST_INSUF;
                else begin
                  bal_tab[src_idx] <= src_bal - amount_q;
                  rsp_balance      <= src_bal - amount_q;
                end
              end
              OP_DEP: begin
                if (dep_sum[19]) rsp_status <= ST_OVF;
                else begin
                  bal_tab[src_idx] <= dep_sum[18:0];
                  rsp_balance      <= dep_sum[18:0];
                end
              end
              OP_XFER: begin
                if (!dst_found || dst_idx == src_idx) rsp_status <= ST_BAD_DST;
                else if (amount_q > src_bal)          rsp_status <= ST_INSUF;
                else if (dst_sum[19])                 rsp_status <= ST_OVF;
                else begin
                  bal_tab[src_idx] <= src_bal - amount_q;
                  bal_tab[dst_idx] <= dst_sum[18:0];
                  rsp_balance      <= src_bal - amount_q;
                end
              end
              OP_CPIN: pin_tab[src_idx] <= new_pin_q;
              default: ;
            endcase
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_account_server.sv
// Directed self-checking bench for atm_account_server with default parameters.
module tb_atm_account_server;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [16:0] req_acct = '0, req_pin = '0, req_dst_acct = '0, req_new_pin = '0;
  logic [18:0] req_amount = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_status;
  logic [18:0] rsp_balance;
  logic [1:0]  rsp_tries_left;

  int tests = 0;
  int fails = 0;

  logic [2:0]  r_st;
  logic [18:0] r_bal;
  logic [1:0]  r_tr;
  int          r_lat;

  atm_account_server dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acct(req_acct), .req_pin(req_pin), .req_dst_acct(req_dst_acct),
    .req_amount(req_amount), .req_new_pin(req_new_pin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .rsp_tries_left(rsp_tries_left)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drives one request from IDLE, measures accept-to-rsp_valid latency, and
  // optionally completes the response handshake.
  task automatic do_req(input logic [2:0] op, input logic [16:0] acct, input logic [16:0] pin,
                        input logic [16:0] dst, input logic [18:0] amt, input logic [16:0] npin,
                        input bit release_rsp);
    @(negedge clk);
    req_op = op; req_acct = acct; req_pin = pin; req_dst_acct = dst;
    req_amount = amt; req_new_pin = npin; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        r_lat = c;
        break;
      end
    end
    r_st = rsp_status; r_bal = rsp_balance; r_tr = rsp_tries_left;
    if (r_lat < 0) begin
      tests++; fails++;
      $display("FAIL timeout op=%0d acct=%h: rsp_valid never rose", op, acct);
    end
    if (release_rsp) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_status, rsp_balance, rsp_tries_left} !== {1'b1, 1'b0, 3'd0, 19'd0, 2'd0}) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%0d vld=%0d st=%0d bal=%0d tr=%0d, expected 1 0 0 0 0",
               req_ready, rsp_valid, rsp_status, rsp_balance, rsp_tries_left);
    end
    do_req(3'd1, 17'h04D5, 17'h1F61, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd1000, 2'd3} || r_lat != 5) begin
      fails++;
      $display("FAIL reset_balance_last: got st=%0d bal=%0d tr=%0d lat=%0d, expected 0 1000 3 5", r_st, r_bal, r_tr, r_lat);
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    do_req(3'd2, 17'h04D2, 17'h1F5E, 17'h0, 19'd500, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd500, 2'd3} || r_lat != 5) begin
      fails++;
      $display("FAIL withdraw_500: got st=%0d bal=%0d tr=%0d lat=%0d, expected 0 500 3 5", r_st, r_bal, r_tr, r_lat);
    end
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_handshake: got rdy=%0d vld=%0d, expected 1 0", req_ready, rsp_valid);
    end
    do_req(3'd2, 17'h04D2, 17'h1F5E, 17'h0, 19'd500, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd0, 2'd3}) begin
      fails++;
      $display("FAIL withdraw_to_zero: got st=%0d bal=%0d tr=%0d, expected 0 0 3", r_st, r_bal, r_tr);
    end
  endtask

  task automatic test_lockout();
    apply_reset();
    do_req(3'd0, 17'h04D3, 17'h0000, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd2, 19'd1000, 2'd2}) begin
      fails++;
      $display("FAIL bad_pin_1: got st=%0d bal=%0d tr=%0d, expected 2 1000 2", r_st, r_bal, r_tr);
    end
    do_req(3'd1, 17'h04D3, 17'h1F5F, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd1000, 2'd3}) begin
      fails++;
      $display("FAIL tries_restore: got st=%0d bal=%0d tr=%0d, expected 0 1000 3", r_st, r_bal, r_tr);
    end
    for (int k = 0; k < 3; k++) begin
      do_req(3'd0, 17'h04D3, 17'h1F5E, 17'h0, 19'd0, 17'h0, 1'b1);
      tests++;
      if ({r_st, r_bal, r_tr} !== {3'd2, 19'd1000, 2'(2 - k)}) begin
        fails++;
        $display("FAIL bad_pin_seq%0d: got st=%0d bal=%0d tr=%0d, expected 2 1000 %0d", k, r_st, r_bal, r_tr, 2 - k);
      end
    end
    do_req(3'd1, 17'h04D3, 17'h1F5F, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd3, 19'd1000, 2'd0}) begin
      fails++;
      $display("FAIL locked: got st=%0d bal=%0d tr=%0d, expected 3 1000 0", r_st, r_bal, r_tr);
    end
  endtask

  task automatic test_limits();
    apply_reset();
    do_req(3'd2, 17'h04D2, 17'h1F5E, 17'h0, 19'd1500, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd4, 19'd1000, 2'd3}) begin
      fails++;
      $display("FAIL insufficient: got st=%0d bal=%0d tr=%0d, expected 4 1000 3", r_st, r_bal, r_tr);
    end
    do_req(3'd3, 17'h04D2, 17'h1F5E, 17'h0, 19'd524000, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd5, 19'd1000, 2'd3}) begin
      fails++;
      $display("FAIL overflow: got st=%0d bal=%0d tr=%0d, expected 5 1000 3", r_st, r_bal, r_tr);
    end
    do_req(3'd3, 17'h04D2, 17'h1F5E, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd1000, 2'd3}) begin
      fails++;
      $display("FAIL deposit_zero: got st=%0d bal=%0d tr=%0d, expected 0 1000 3", r_st, r_bal, r_tr);
    end
    do_req(3'd3, 17'h04D2, 17'h1F5E, 17'h0, 19'd523287, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd524287, 2'd3}) begin
      fails++;
      $display("FAIL deposit_to_max: got st=%0d bal=%0d tr=%0d, expected 0 524287 3", r_st, r_bal, r_tr);
    end
    do_req(3'd7, 17'h04D2, 17'h1F5E, 17'h0, 19'd5, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd6, 19'd0, 2'd0} || r_lat != 1) begin
      fails++;
      $display("FAIL bad_op_111: got st=%0d bal=%0d tr=%0d lat=%0d, expected 6 0 0 1", r_st, r_bal, r_tr, r_lat);
    end
    do_req(3'd6, 17'h04D3, 17'h1F5F, 17'h0, 19'd5, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd6, 19'd0, 2'd0} || r_lat != 1) begin
      fails++;
      $display("FAIL bad_op_110: got st=%0d bal=%0d tr=%0d lat=%0d, expected 6 0 0 1", r_st, r_bal, r_tr, r_lat);
    end
  endtask

  task automatic test_transfer();
    apply_reset();
    do_req(3'd4, 17'h04D2, 17'h1F5E, 17'h04D3, 19'd200, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd800, 2'd3} || r_lat != 9) begin
      fails++;
      $display("FAIL xfer_200: got st=%0d bal=%0d tr=%0d lat=%0d, expected 0 800 3 9", r_st, r_bal, r_tr, r_lat);
    end
    do_req(3'd1, 17'h04D3, 17'h1F5F, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal} !== {3'd0, 19'd1200}) begin
      fails++;
      $display("FAIL xfer_dst_bal: got st=%0d bal=%0d, expected 0 1200", r_st, r_bal);
    end
    do_req(3'd4, 17'h04D2, 17'h1F5E, 17'h04D2, 19'd10, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal} !== {3'd7, 19'd800}) begin
      fails++;
      $display("FAIL xfer_self: got st=%0d bal=%0d, expected 7 800", r_st, r_bal);
    end
    do_req(3'd4, 17'h04D2, 17'h1F5E, 17'h01111, 19'd10, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal} !== {3'd7, 19'd800}) begin
      fails++;
      $display("FAIL xfer_no_dst: got st=%0d bal=%0d, expected 7 800", r_st, r_bal);
    end
    do_req(3'd4, 17'h04D2, 17'h1F5E, 17'h04D3, 19'd900, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal} !== {3'd4, 19'd800}) begin
      fails++;
      $display("FAIL xfer_insuf: got st=%0d bal=%0d, expected 4 800", r_st, r_bal);
    end
    do_req(3'd3, 17'h04D3, 17'h1F5F, 17'h0, 19'd523000, 17'h0, 1'b1);
    do_req(3'd4, 17'h04D2, 17'h1F5E, 17'h04D3, 19'd100, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal} !== {3'd5, 19'd800}) begin
      fails++;
      $display("FAIL xfer_dst_ovf: got st=%0d bal=%0d, expected 5 800", r_st, r_bal);
    end
    do_req(3'd1, 17'h04D3, 17'h1F5F, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal} !== {3'd0, 19'd524200}) begin
      fails++;
      $display("FAIL xfer_ovf_dst_kept: got st=%0d bal=%0d, expected 0 524200", r_st, r_bal);
    end
    do_req(3'd4, 17'h04D2, 17'h1F5E, 17'h04D5, 19'd50, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal} !== {3'd0, 19'd750} || r_lat != 9) begin
      fails++;
      $display("FAIL xfer_last: got st=%0d bal=%0d lat=%0d, expected 0 750 9", r_st, r_bal, r_lat);
    end
    do_req(3'd1, 17'h04D5, 17'h1F61, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal} !== {3'd0, 19'd1050}) begin
      fails++;
      $display("FAIL xfer_last_dst: got st=%0d bal=%0d, expected 0 1050", r_st, r_bal);
    end
    do_req(3'd4, 17'h01234, 17'h1F5E, 17'h04D3, 19'd10, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd1, 19'd0, 2'd0} || r_lat != 5) begin
      fails++;
      $display("FAIL xfer_bad_src: got st=%0d bal=%0d tr=%0d lat=%0d, expected 1 0 0 5", r_st, r_bal, r_tr, r_lat);
    end
  endtask

  task automatic test_change_pin();
    apply_reset();
    do_req(3'd5, 17'h04D4, 17'h1F60, 17'h0, 19'd0, 17'h0ABCD, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd1000, 2'd3}) begin
      fails++;
      $display("FAIL change_pin: got st=%0d bal=%0d tr=%0d, expected 0 1000 3", r_st, r_bal, r_tr);
    end
    do_req(3'd0, 17'h04D4, 17'h1F60, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_tr} !== {3'd2, 2'd2}) begin
      fails++;
      $display("FAIL old_pin: got st=%0d tr=%0d, expected 2 2", r_st, r_tr);
    end
    do_req(3'd0, 17'h04D4, 17'h0ABCD, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd0, 19'd1000, 2'd3}) begin
      fails++;
      $display("FAIL new_pin: got st=%0d bal=%0d tr=%0d, expected 0 1000 3", r_st, r_bal, r_tr);
    end
    do_req(3'd1, 17'h01234, 17'h1F5E, 17'h0, 19'd0, 17'h0, 1'b1);
    tests++;
    if ({r_st, r_bal, r_tr} !== {3'd1, 19'd0, 2'd0}) begin
      fails++;
      $display("FAIL bad_acct: got st=%0d bal=%0d tr=%0d, expected 1 0 0", r_st, r_bal, r_tr);
    end
  endtask

  task automatic test_hold();
    int bad;
    apply_reset();
    do_req(3'd2, 17'h04D2, 17'h1F5E, 17'h0, 19'd100, 17'h0, 1'b0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({rsp_valid, req_ready, rsp_status, rsp_balance, rsp_tries_left} !== {1'b1, 1'b0, 3'd0, 19'd900, 2'd3}) begin
        fails++;
        $display("FAIL hold_cycle%0d: got vld=%0d rdy=%0d st=%0d bal=%0d tr=%0d, expected 1 0 0 900 3",
                 c, rsp_valid, req_ready, rsp_status, rsp_balance, rsp_tries_left);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    tests++;
    if ({rsp_valid, req_ready} !== {1'b0, 1'b1}) begin
      fails++;
      $display("FAIL hold_release: got vld=%0d rdy=%0d, expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_req(3'd2, 17'h04D2, 17'h1F5E, 17'h0, 19'd300, 17'h0, 1'b1);
    @(negedge clk);
    req_op = 3'd2; req_acct = 17'h04D3; req_pin = 17'h1F5F; req_amount = 19'd400; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_status, rsp_balance, rsp_tries_left} !== {1'b1, 1'b0, 3'd0, 19'd0, 2'd0}) begin
      fails++;
      $display("FAIL mid_reset_outputs: got rdy=%0d vld=%0d st=%0d bal=%0d tr=%0d, expected 1 0 0 0 0",
               req_ready, rsp_valid, rsp_status, rsp_balance, rsp_tries_left);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(3'd1, 17'(17'h04D2 + i), 17'(17'h1F5E + i), 17'h0, 19'd0, 17'h0, 1'b1);
      tests++;
      if ({r_st, r_bal, r_tr} !== {3'd0, 19'd1000, 2'd3}) begin
        fails++;
        $display("FAIL mid_reset_bal%0d: got st=%0d bal=%0d tr=%0d, expected 0 1000 3", i, r_st, r_bal, r_tr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_withdraw();
    test_lockout();
    test_limits();
    test_transfer();
    test_change_pin();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
